// File: rtl/scope_capture_sequencer_if.sv
// Sample, trigger-control and display-side signals of the scope capture sequencer.
// The slave modport is the sequencer's view; the master modport is the view of whatever drives it.
interface scope_capture_sequencer_if #(
  parameter int DW = 11
);
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] trig_level;
  logic          trig_falling;
  logic [1:0]    trig_mode;
  logic          arm;
  logic          disp_frame_start;
  logic          disp_line_start;
  logic          disp_ack;
  logic [DW-1:0] disp_data;
  logic [2:0]    capt_state;
  logic          trig_pulse;
  logic          trig_forced;
  logic          swap_pulse;

  modport master (
    output adc_valid, adc_data, trig_level, trig_falling, trig_mode, arm,
           disp_frame_start, disp_line_start, disp_ack,
    input  disp_data, capt_state, trig_pulse, trig_forced, swap_pulse
  );

  modport slave (
    input  adc_valid, adc_data, trig_level, trig_falling, trig_mode, arm,
           disp_frame_start, disp_line_start, disp_ack,
    output disp_data, capt_state, trig_pulse, trig_forced, swap_pulse
  );
endinterface

// File: rtl/scope_capture_sequencer.sv
// Ping-pong oscilloscope capture: pre-trigger history, edge or auto-timeout trigger,
// post-trigger fill, then a swap to the display buffer at the next frame start.
module scope_capture_sequencer #(
  parameter int DW           = 11,
  parameter int AW           = 10,
  parameter int PRETRIG      = 512,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  scope_capture_sequencer_if.slave bus
);

  localparam int              DEPTH    = 1 << AW;
  localparam int              TW       = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AW:0]     PRE_LEN  = (AW+1)'(PRETRIG);
  localparam logic [AW:0]     POST_LEN = (AW+1)'(DEPTH - PRETRIG);
  localparam logic [AW-1:0]   PRE_OFS  = AW'(PRETRIG);
  localparam logic [TW-1:0]   TO_LEN   = TW'(AUTO_TIMEOUT);
  localparam logic [1:0]      MODE_AUTO   = 2'b00;
  localparam logic [1:0]      MODE_SINGLE = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  logic          cap_sel;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] disp_start;
  logic [AW-1:0] rd_col;
  logic [AW:0]   pre_cnt;
  logic [AW:0]   post_cnt;
  logic [TW-1:0] to_cnt;
  logic [DW-1:0] prev;
  logic [DW-1:0] disp_data;
  logic          trig_pulse;
  logic          trig_forced;
  logic          swap_pulse;

  logic [DW-1:0] mem [2][DEPTH];

  logic          wr_en;
  logic          trig_hit;
  logic          timeout;
  logic [AW:0]   pre_inc;
  logic [AW:0]   post_inc;
  logic [TW:0]   to_inc;
  logic [AW-1:0] rd_addr;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    wr_en    = bus.adc_valid && (state == PRE || state == WAIT || state == POST);
    trig_hit = bus.trig_falling
             ? (prev >= bus.trig_level) && (bus.adc_data <  bus.trig_level)
             : (prev <  bus.trig_level) && (bus.adc_data >= bus.trig_level);
    pre_inc  = pre_cnt + (AW+1)'(1);
    post_inc = post_cnt + (AW+1)'(1);
    to_inc   = {1'b0, to_cnt} + (TW+1)'(1);
    timeout  = (bus.trig_mode == MODE_AUTO) && (to_inc >= {1'b0, TO_LEN});
    rd_addr  = disp_start + (bus.disp_line_start ? '0 : rd_col);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cap_sel     <= 1'b0;
      wr_addr     <= '0;
      start_addr  <= '0;
      disp_start  <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      to_cnt      <= '0;
      prev        <= '0;
      trig_pulse  <= 1'b0;
      trig_forced <= 1'b0;
      swap_pulse  <= 1'b0;
    end else begin
      trig_pulse <= 1'b0;
      swap_pulse <= 1'b0;
      if (bus.adc_valid) prev <= bus.adc_data;
      if (wr_en)         wr_addr <= wr_addr + AW'(1);

      case (state)
        IDLE: begin
          if (bus.trig_mode != MODE_SINGLE || bus.arm) begin
            state    <= PRE;
            wr_addr  <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        PRE: begin
          if (bus.adc_valid) begin
            pre_cnt <= pre_inc;
            if (pre_inc == PRE_LEN) state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.adc_valid) begin
            if (to_cnt != TO_LEN) to_cnt <= to_inc[TW-1:0];
            // A real edge on the timeout sample still counts as a real trigger.
            if (trig_hit || timeout) begin
              start_addr  <= wr_addr - PRE_OFS;
              trig_pulse  <= 1'b1;
              trig_forced <= !trig_hit;
              post_cnt    <= (AW+1)'(1);
              state       <= (POST_LEN == (AW+1)'(1)) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (bus.adc_valid) begin
            post_cnt <= post_inc;
            if (post_inc == POST_LEN) state <= DONE;
          end
        end
        DONE: begin
          if (bus.disp_frame_start) begin
            cap_sel    <= ~cap_sel;
            disp_start <= start_addr;
            swap_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the sample buffers carry no reset so they can map onto block RAM; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cap_sel][wr_addr] <= bus.adc_data;
  end

  // Display side always reads the buffer not selected for capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_col    <= '0;
      disp_data <= '0;
    end else if (bus.disp_ack) begin
      disp_data <= mem[~cap_sel][rd_addr];
      if (bus.disp_line_start)  rd_col <= AW'(1);
      else if (rd_col != '1)    rd_col <= rd_col + AW'(1);
    end else if (bus.disp_line_start) begin
      rd_col <= '0;
    end
  end

  assign bus.disp_data   = disp_data;
  assign bus.capt_state  = state;
  assign bus.trig_pulse  = trig_pulse;
  assign bus.trig_forced = trig_forced;
  assign bus.swap_pulse  = swap_pulse;

endmodule

// File: tb/tb_scope_capture_sequencer.sv
// Directed-sequence bench with randomized sample streams; expected trigger points and
// display contents come from a sample-index model of the capture and display buffers.
module tb_scope_capture_sequencer;

  localparam int DW           = 11;
  localparam int AW           = 10;
  localparam int DEPTH        = 1 << AW;
  localparam int PRETRIG      = 512;
  localparam int AUTO_TIMEOUT = 16;
  localparam int POST_LEN     = DEPTH - PRETRIG;
  localparam int NS           = 4096;

  logic clk = 1'b0;
  logic rst;

  scope_capture_sequencer_if #(.DW(DW)) bus ();

  scope_capture_sequencer #(
    .DW(DW), .AW(AW), .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] s [NS];
  logic [DW-1:0] model_buf [2][DEPTH];
  bit            m_cap_sel   = 1'b0;
  int            m_disp_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_col(input int c);
    return model_buf[m_cap_sel ? 0 : 1][(m_disp_start + c) % DEPTH];
  endfunction

  // Index of the accepted trigger sample counted from the first captured sample.
  function automatic int model_trig(input bit auto_wait, input bit falling, input int level,
                                    output bit forced);
    forced = 1'b0;
    for (int i = PRETRIG; i < NS; i++) begin
      if (falling ? (int'(s[i-1]) >= level && int'(s[i]) < level)
                  : (int'(s[i-1]) <  level && int'(s[i]) >= level))
        return i;
      if (auto_wait && (i - PRETRIG + 1 == AUTO_TIMEOUT)) begin
        forced = 1'b1;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic gen_ramp();
    for (int i = 0; i < NS; i++) s[i] = DW'(i % DEPTH);
  endtask

  task automatic gen_const(input int v);
    for (int i = 0; i < NS; i++) s[i] = DW'(v);
  endtask

  task automatic gen_cross(input int idx, input int level, input bit falling);
    for (int i = 0; i < NS; i++) begin
      if (i < idx)       s[i] = falling ? DW'($urandom_range(2047, level)) : DW'($urandom_range(level - 1, 0));
      else if (i == idx) s[i] = falling ? DW'($urandom_range(level - 1, 0)) : DW'($urandom_range(2047, level));
      else               s[i] = DW'($urandom_range(2047, 0));
    end
  endtask

  task automatic run_capture(input bit auto_wait, input bit falling, input int level,
                             input int rst_at, input bit frame_on_last, input int switch_at,
                             output int trig_idx);
    bit forced;
    bit v;
    bit last;
    int n_send;
    int sent   = 0;
    int pulses = 0;
    int swaps  = 0;
    trig_idx = model_trig(auto_wait, falling, level, forced);
    n_send   = trig_idx + POST_LEN;
    bus.trig_level   = DW'(level);
    bus.trig_falling = falling;
    check("cap_start_pre", 32'(bus.capt_state), 1);
    while (sent < n_send) begin
      if (sent == rst_at) begin
        bus.adc_valid = 1'b0; bus.arm = 1'b0; bus.disp_frame_start = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_disp_data", 32'(bus.disp_data), 0);
        check("rst_state", 32'(bus.capt_state), 0);
        check("rst_trig_pulse", 32'(bus.trig_pulse), 0);
        check("rst_trig_forced", 32'(bus.trig_forced), 0);
        check("rst_swap_pulse", 32'(bus.swap_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        m_cap_sel    = 1'b0;
        m_disp_start = 0;
        @(negedge clk);
        check("rst_restart_pre", 32'(bus.capt_state), 1);
        return;
      end
      if (sent == switch_at) bus.trig_mode = 2'b01;
      last = (sent == n_send - 1);
      v = (last && frame_on_last) || ($urandom_range(3, 0) != 0);
      bus.adc_valid        = v;
      bus.adc_data         = v ? s[sent] : DW'($urandom);
      bus.arm              = ($urandom_range(31, 0) == 0);
      bus.disp_frame_start = (v && last && frame_on_last) || ($urandom_range(15, 0) == 0);
      @(negedge clk);
      if (bus.trig_pulse) pulses++;
      if (bus.swap_pulse) swaps++;
      if (v) begin
        model_buf[m_cap_sel ? 1 : 0][sent % DEPTH] = s[sent];
        if (sent == PRETRIG - 1) check("wait_entry", 32'(bus.capt_state), 2);
        if (sent == trig_idx) begin
          check("trig_pulse", 32'(bus.trig_pulse), 1);
          check("trig_forced", 32'(bus.trig_forced), 32'(forced));
          if (!last) check("post_entry", 32'(bus.capt_state), 3);
        end
        sent++;
      end
    end
    bus.adc_valid = 1'b0; bus.arm = 1'b0; bus.disp_frame_start = 1'b0;
    check("done_state", 32'(bus.capt_state), 4);
    check("no_early_swap", 32'(swaps), 0);
    check("one_trigger", 32'(pulses), 1);
    repeat (3) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = DW'($urandom);
      @(negedge clk);
    end
    bus.adc_valid = 1'b0;
    check("done_hold", 32'(bus.capt_state), 4);
  endtask

  task automatic do_swap(input bit to_pre, input int trig_idx);
    bus.disp_frame_start = 1'b1;
    @(negedge clk);
    bus.disp_frame_start = 1'b0;
    check("swap_pulse", 32'(bus.swap_pulse), 1);
    check("swap_to_idle", 32'(bus.capt_state), 0);
    m_cap_sel    = !m_cap_sel;
    m_disp_start = (trig_idx - PRETRIG) % DEPTH;
    @(negedge clk);
    check("swap_single_cycle", 32'(bus.swap_pulse), 0);
    check("after_swap_state", 32'(bus.capt_state), to_pre ? 1 : 0);
  endtask

  task automatic read_display();
    logic [DW-1:0] last_v;
    string tag;
    bit a;
    int c;
    bus.disp_line_start = 1'b1;
    bus.disp_ack        = 1'b1;
    @(negedge clk);
    bus.disp_line_start = 1'b0;
    bus.disp_ack        = 1'b0;
    last_v = exp_col(0);
    check("disp_col0", 32'(bus.disp_data), 32'(last_v));
    c = 1;
    while (c < DEPTH) begin
      a = ($urandom_range(3, 0) != 0);
      bus.disp_ack = a;
      @(negedge clk);
      if (a) begin
        last_v = exp_col(c);
        tag = (c == PRETRIG) ? "disp_col_trig" : "disp_col";
        check(tag, 32'(bus.disp_data), 32'(last_v));
        c++;
      end else begin
        check("disp_hold", 32'(bus.disp_data), 32'(last_v));
      end
    end
    bus.disp_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("disp_saturate", 32'(bus.disp_data), 32'(exp_col(DEPTH - 1)));
    end
    bus.disp_ack        = 1'b0;
    bus.disp_line_start = 1'b1;
    @(negedge clk);
    bus.disp_line_start = 1'b0;
    check("disp_hold_line", 32'(bus.disp_data), 32'(exp_col(DEPTH - 1)));
    bus.disp_ack = 1'b1;
    @(negedge clk);
    check("disp_restart_col0", 32'(bus.disp_data), 32'(exp_col(0)));
    @(negedge clk);
    check("disp_restart_col1", 32'(bus.disp_data), 32'(exp_col(1)));
    bus.disp_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    bus.adc_valid = 1'b0; bus.adc_data = '0; bus.trig_level = '0; bus.trig_falling = 1'b0;
    bus.trig_mode = 2'b01; bus.arm = 1'b0; bus.disp_frame_start = 1'b0;
    bus.disp_line_start = 1'b0; bus.disp_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_disp_data", 32'(bus.disp_data), 0);
    check("reset_state", 32'(bus.capt_state), 0);
    check("reset_trig_pulse", 32'(bus.trig_pulse), 0);
    check("reset_trig_forced", 32'(bus.trig_forced), 0);
    check("reset_swap_pulse", 32'(bus.swap_pulse), 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp, normal rising at 500.
    gen_ramp();
    run_capture(1'b0, 1'b0, 500, -1, 1'b0, -1, t);
    do_swap(1'b1, t);
    read_display();

    // Wrap-around: falling trigger at sample 1124, mode switched auto -> normal during PRE.
    bus.trig_mode = 2'b00;
    gen_cross(1124, 700, 1'b1);
    run_capture(1'b0, 1'b1, 700, -1, 1'b0, 100, t);
    do_swap(1'b1, t);
    read_display();

    // Reset at address 700 during POST, then the old display buffer is still shown.
    gen_cross(600, 300, 1'b0);
    run_capture(1'b0, 1'b0, 300, 700, 1'b0, -1, t);
    read_display();
    gen_cross(800, 1000, 1'b1);
    run_capture(1'b0, 1'b1, 1000, -1, 1'b0, -1, t);
    do_swap(1'b1, t);
    read_display();

    // Auto mode, constant input below level: forced trigger after the timeout.
    bus.trig_mode = 2'b00;
    gen_const(100);
    run_capture(1'b1, 1'b0, 500, -1, 1'b0, -1, t);
    bus.trig_mode = 2'b10;
    do_swap(1'b0, t);
    read_display();

    // Single mode: idle until armed, exactly one capture.
    for (int k = 0; k < 20; k++) begin
      bus.adc_valid        = 1'($urandom);
      bus.adc_data         = DW'($urandom);
      bus.disp_frame_start = (k % 5 == 0);
      @(negedge clk);
      check("single_idle", 32'(bus.capt_state), 0);
      check("idle_no_swap", 32'(bus.swap_pulse), 0);
    end
    bus.adc_valid = 1'b0; bus.disp_frame_start = 1'b0;
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    gen_cross(700, 200, 1'b0);
    run_capture(1'b0, 1'b0, 200, -1, 1'b0, -1, t);
    do_swap(1'b0, t);
    read_display();
    repeat (5) begin
      @(negedge clk);
      check("single_stays_idle", 32'(bus.capt_state), 0);
    end

    // Mode 11 behaves as normal; frame pulse coincident with POST -> DONE is ignored.
    bus.trig_mode = 2'b11;
    @(negedge clk);
    gen_cross(900, 1500, 1'b0);
    run_capture(1'b0, 1'b0, 1500, -1, 1'b1, -1, t);
    do_swap(1'b1, t);
    read_display();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
